// File: rtl/note_sprite_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : note_sprite_pkg                                             |
// | Brief  : Shared types and constants for the note sprite scheduler.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package note_sprite_pkg;

  localparam int SPRITE_W     = 20;
  localparam int SPRITE_H     = 30;
  localparam int SPRITE_DEPTH = 600;

  // Storage width of slot coordinates; matches the default HW of the scheduler.
  localparam int COORD_W      = 10;

  typedef enum logic [1:0] {
    GLY_QTR_UP   = 2'd0,
    GLY_QTR_DOWN = 2'd1,
    GLY_HALF     = 2'd2,
    GLY_WHOLE    = 2'd3
  } glyph_t;

  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    glyph_t             glyph;
  } slot_t;

  typedef enum logic [0:0] {
    S_LOAD    = 1'b0,
    S_PENDING = 1'b1
  } sched_state_t;

  // Glyph ROM address row*20+col built from shifts; row<30, col<20 so max 599.
  function automatic logic [9:0] rom_index(input logic [4:0] row, input logic [4:0] col);
    logic [9:0] r10;
    r10 = {5'd0, row};
    return (r10 << 4) + (r10 << 2) + {5'd0, col};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_hit_prio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sprite_hit_prio                                             |
// | Brief  : Per-slot box hit test plus lowest-index priority encoder.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module sprite_hit_prio
  import note_sprite_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int HW        = 10,
  localparam int IW       = $clog2(NUM_SLOTS)
) (
  input  logic [HW-1:0]            hcount,
  input  logic [HW-1:0]            vcount,
  input  slot_t [NUM_SLOTS-1:0]    slots,
  output logic                     hit,
  output logic [IW-1:0]            winner,
  output logic [4:0]               row,
  output logic [4:0]               col
);

  // One extra bit keeps x+20 / y+30 from wrapping at the screen edge.
  localparam logic [HW:0] c_box_w = SPRITE_W[HW:0];
  localparam logic [HW:0] c_box_h = SPRITE_H[HW:0];

  logic [NUM_SLOTS-1:0] w_hit_vec;
  logic [4:0]           w_row [NUM_SLOTS];
  logic [4:0]           w_col [NUM_SLOTS];

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    logic [HW:0] w_h;
    logic [HW:0] w_v;
    logic [HW:0] w_x;
    logic [HW:0] w_y;

    assign w_h = {1'b0, hcount};
    assign w_v = {1'b0, vcount};
    assign w_x = {1'b0, HW'(slots[i].x)};
    assign w_y = {1'b0, HW'(slots[i].y)};

    assign w_hit_vec[i] = slots[i].en
                        && (w_h >= w_x) && (w_h < w_x + c_box_w)
                        && (w_v >= w_y) && (w_v < w_y + c_box_h);

    // Only meaningful on a hit, where the offsets are below 20 / 30.
    assign w_col[i] = 5'(hcount - HW'(slots[i].x));
    assign w_row[i] = 5'(vcount - HW'(slots[i].y));
  end

  // Scan from the top so the lowest-index hitting slot is written last and wins.
  always_comb begin
    hit    = 1'b0;
    winner = '0;
    row    = '0;
    col    = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_hit_vec[i]) begin
        hit    = 1'b1;
        winner = IW'(i);
        row    = w_row[i];
        col    = w_col[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/note_sprite_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : note_sprite_scheduler                                       |
// | Brief  : Shares one note-glyph ROM among NUM_SLOTS on-screen notes;  |
// |          shadow/active slot tables, 3-stage pixel pipeline.          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module note_sprite_scheduler
  import note_sprite_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int HW        = 10,
  localparam int IW       = $clog2(NUM_SLOTS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_valid,
  input  logic [HW-1:0] hcount,
  input  logic [HW-1:0] vcount,
  input  logic          frame_start,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [IW-1:0] wr_slot,
  input  logic          wr_en,
  input  logic [HW-1:0] wr_x,
  input  logic [HW-1:0] wr_y,
  input  logic [1:0]    wr_glyph,
  input  logic          commit,
  output logic          commit_pending,
  output logic [9:0]    rom_addr,
  output logic [1:0]    rom_glyph,
  input  logic          rom_pixel,
  output logic          pix_out_valid,
  output logic          note_on
);

  sched_state_t           r_state;
  sched_state_t           w_state_nxt;
  slot_t [NUM_SLOTS-1:0]  r_shadow;
  slot_t [NUM_SLOTS-1:0]  r_active;
  logic                   w_wr_fire;
  logic                   w_apply;

  logic                   w_hit;
  logic                   w_hit_q;
  logic [IW-1:0]          w_winner;
  logic [4:0]             w_row;
  logic [4:0]             w_col;

  logic [9:0]             r_rom_addr;
  glyph_t                 r_rom_glyph;
  logic                   r_hit_d1;
  logic                   r_valid_d1;
  logic                   r_hit_d2;
  logic                   r_valid_d2;
  logic                   r_note_on;
  logic                   r_pix_out_valid;

  // Scheduler state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_LOAD;
    else       r_state <= w_state_nxt;
  end

  // Next state: LOAD waits for commit, PENDING waits for the frame boundary.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:    if (commit)      w_state_nxt = S_PENDING;
      S_PENDING: if (frame_start) w_state_nxt = S_LOAD;
      default:                    w_state_nxt = S_LOAD;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    wr_ready       = 1'b0;
    commit_pending = 1'b0;
    case (r_state)
      S_LOAD:    wr_ready       = 1'b1;
      S_PENDING: commit_pending = 1'b1;
      default:   wr_ready       = 1'b0;
    endcase
  end

  assign w_wr_fire = wr_valid & wr_ready;
  assign w_apply   = (r_state == S_PENDING) & frame_start;

  // Shadow table: written only while loading, so a pending commit sees a frozen copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= '0;
    end else if (w_wr_fire) begin
      r_shadow[wr_slot] <= '{en: wr_en, x: COORD_W'(wr_x), y: COORD_W'(wr_y),
                             glyph: glyph_t'(wr_glyph)};
    end
  end

  // Active table: whole-table copy on the frame boundary only.
  always_ff @(posedge clk) begin
    if (reset)        r_active <= '0;
    else if (w_apply) r_active <= r_shadow;
  end

  sprite_hit_prio #(
    .NUM_SLOTS (NUM_SLOTS),
    .HW        (HW)
  ) u_hit_prio (
    .hcount (hcount),
    .vcount (vcount),
    .slots  (r_active),
    .hit    (w_hit),
    .winner (w_winner),
    .row    (w_row),
    .col    (w_col)
  );

  assign w_hit_q = w_hit & pix_valid;

  // Stage 1: drive the shared ROM with the winner's address and glyph.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rom_addr  <= '0;
      r_rom_glyph <= GLY_QTR_UP;
      r_hit_d1    <= 1'b0;
      r_valid_d1  <= 1'b0;
    end else begin
      r_rom_addr  <= w_hit_q ? rom_index(w_row, w_col) : 10'd0;
      r_rom_glyph <= w_hit_q ? r_active[w_winner].glyph : GLY_QTR_UP;
      r_hit_d1    <= w_hit_q;
      r_valid_d1  <= pix_valid;
    end
  end

  // Stage 2: carry hit/valid alongside the ROM's own output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_d2   <= 1'b0;
      r_valid_d2 <= 1'b0;
    end else begin
      r_hit_d2   <= r_hit_d1;
      r_valid_d2 <= r_valid_d1;
    end
  end

  // Stage 3: composite ROM ink with the aligned hit/valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_note_on       <= 1'b0;
      r_pix_out_valid <= 1'b0;
    end else begin
      r_note_on       <= rom_pixel & r_hit_d2 & r_valid_d2;
      r_pix_out_valid <= r_valid_d2;
    end
  end

  assign rom_addr      = r_rom_addr;
  assign rom_glyph     = r_rom_glyph;
  assign note_on       = r_note_on;
  assign pix_out_valid = r_pix_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_note_sprite_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_note_sprite_scheduler                                    |
// | Brief  : Directed vector table, hand sequences and random stimulus   |
// |          against a behavioural model of the note sprite scheduler.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_note_sprite_scheduler;
  import note_sprite_pkg::*;

  localparam int NS = 8;
  localparam int HW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_valid = 1'b0;
  logic [HW-1:0] hcount = '0;
  logic [HW-1:0] vcount = '0;
  logic          frame_start = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [2:0]    wr_slot = '0;
  logic          wr_en = 1'b0;
  logic [HW-1:0] wr_x = '0;
  logic [HW-1:0] wr_y = '0;
  logic [1:0]    wr_glyph = '0;
  logic          commit = 1'b0;
  logic          commit_pending;
  logic [9:0]    rom_addr;
  logic [1:0]    rom_glyph;
  logic          rom_pixel = 1'b0;
  logic          pix_out_valid;
  logic          note_on;

  note_sprite_scheduler #(.NUM_SLOTS(NS), .HW(HW)) dut (
    .clk            (clk),
    .reset          (reset),
    .pix_valid      (pix_valid),
    .hcount         (hcount),
    .vcount         (vcount),
    .frame_start    (frame_start),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_slot        (wr_slot),
    .wr_en          (wr_en),
    .wr_x           (wr_x),
    .wr_y           (wr_y),
    .wr_glyph       (wr_glyph),
    .commit         (commit),
    .commit_pending (commit_pending),
    .rom_addr       (rom_addr),
    .rom_glyph      (rom_glyph),
    .rom_pixel      (rom_pixel),
    .pix_out_valid  (pix_out_valid),
    .note_on        (note_on)
  );

  always #5 clk = ~clk;

  // Glyph ROM content: an arbitrary address/glyph dependent bit pattern.
  function automatic bit rom_bit(input int g, input int a);
    logic [9:0] av;
    av = a[9:0];
    return av[g] ^ av[g + 3] ^ g[0];
  endfunction

  // Registered ROM with one cycle of latency.
  always @(posedge clk) rom_pixel <= rom_bit(int'(rom_glyph), int'(rom_addr));

  // Reference model state.
  bit ms_en [NS];
  int ms_x [NS], ms_y [NS], ms_g [NS];
  bit ma_en [NS];
  int ma_x [NS], ma_y [NS], ma_g [NS];
  bit m_pend;
  int p_addr [3], p_glyph [3];
  bit p_ink [3], p_pv [3];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      ms_en[i] = 0; ms_x[i] = 0; ms_y[i] = 0; ms_g[i] = 0;
      ma_en[i] = 0; ma_x[i] = 0; ma_y[i] = 0; ma_g[i] = 0;
    end
    for (int k = 0; k < 3; k++) begin
      p_addr[k] = 0; p_glyph[k] = 0; p_ink[k] = 0; p_pv[k] = 0;
    end
    m_pend = 0;
  endtask

  // One clock cycle: drive, predict, clock, compare.
  task automatic step(input bit pv, input int hc, input int vc, input bit fs,
                      input bit wv, input int ws, input bit we, input int wx,
                      input int wy, input int wg, input bit cm, input bit rst);
    bit hit;
    int a, g;
    reset = rst; pix_valid = pv; hcount = hc[HW-1:0]; vcount = vc[HW-1:0];
    frame_start = fs; wr_valid = wv; wr_slot = ws[2:0]; wr_en = we;
    wr_x = wx[HW-1:0]; wr_y = wy[HW-1:0]; wr_glyph = wg[1:0]; commit = cm;

    hit = 0; a = 0; g = 0;
    if (pv) begin
      for (int i = 0; i < NS; i++) begin
        if (!hit && ma_en[i] && hc >= ma_x[i] && hc < ma_x[i] + SPRITE_W &&
            vc >= ma_y[i] && vc < ma_y[i] + SPRITE_H) begin
          hit = 1;
          a = (vc - ma_y[i]) * SPRITE_W + (hc - ma_x[i]);
          g = ma_g[i];
        end
      end
    end
    for (int k = 2; k > 0; k--) begin
      p_addr[k] = p_addr[k-1]; p_glyph[k] = p_glyph[k-1];
      p_ink[k] = p_ink[k-1]; p_pv[k] = p_pv[k-1];
    end
    p_addr[0] = a; p_glyph[0] = g; p_ink[0] = hit && rom_bit(g, a); p_pv[0] = pv;

    if (rst) begin
      model_clear();
    end else if (!m_pend) begin
      if (wv) begin
        ms_en[ws] = we; ms_x[ws] = wx; ms_y[ws] = wy; ms_g[ws] = wg;
      end
      if (cm) m_pend = 1;
    end else if (fs) begin
      ma_en = ms_en; ma_x = ms_x; ma_y = ms_y; ma_g = ms_g;
      m_pend = 0;
    end

    @(posedge clk);
    #1;
    chk("rom_addr", int'(rom_addr), p_addr[0]);
    chk("rom_glyph", int'(rom_glyph), p_glyph[0]);
    chk("note_on", int'(note_on), int'(p_ink[2]));
    chk("pix_out_valid", int'(pix_out_valid), int'(p_pv[2]));
    chk("commit_pending", int'(commit_pending), int'(m_pend));
    chk("wr_ready", int'(wr_ready), int'(!m_pend));
  endtask

  typedef struct {
    bit pv; int hc; int vc; bit fs;
    bit wv; int ws; bit we; int wx; int wy; int wg; bit cm;
    int ea; int eg; int en; int epv;   // -1 = not checked
  } vec_t;

  vec_t vecs [22];

  initial begin
    vecs[0]  = '{1, 100, 50, 0,  0, 0, 0,    0,  0, 0, 0,    0, 0, -1, -1};
    vecs[1]  = '{0,   0,  0, 0,  1, 0, 1,  100, 40, 1, 0,    0, 0, -1, -1};
    vecs[2]  = '{0,   0,  0, 0,  0, 0, 0,    0,  0, 0, 1,    0, 0,  0,  1};
    vecs[3]  = '{0,   0,  0, 1,  0, 0, 0,    0,  0, 0, 0,    0, 0, -1, -1};
    vecs[4]  = '{1, 105, 50, 0,  0, 0, 0,    0,  0, 0, 0,  205, 1, -1, -1};
    vecs[5]  = '{0,   0,  0, 0,  1, 3, 1,  110, 40, 2, 1,    0, 0, -1, -1};
    vecs[6]  = '{0,   0,  0, 1,  0, 0, 0,    0,  0, 0, 0,    0, 0,  1,  1};
    vecs[7]  = '{1, 112, 45, 0,  0, 0, 0,    0,  0, 0, 0,  112, 1, -1, -1};
    vecs[8]  = '{1, 115, 45, 0,  0, 0, 0,    0,  0, 0, 0,  115, 1, -1, -1};
    vecs[9]  = '{1, 121, 45, 0,  0, 0, 0,    0,  0, 0, 0,  111, 2, -1, -1};
    vecs[10] = '{0,   0,  0, 0,  1, 5, 1, 1015,  0, 3, 1,    0, 0, -1, -1};
    vecs[11] = '{0,   0,  0, 1,  0, 0, 0,    0,  0, 0, 0,    0, 0, -1, -1};
    vecs[12] = '{1,1020,  0, 0,  0, 0, 0,    0,  0, 0, 0,    5, 3, -1, -1};
    vecs[13] = '{1,   3,  0, 0,  0, 0, 0,    0,  0, 0, 0,    0, 0, -1, -1};
    vecs[14] = '{1,1023, 29, 0,  0, 0, 0,    0,  0, 0, 0,  588, 3, -1, -1};
    vecs[15] = '{1,1015, 30, 0,  0, 0, 0,    0,  0, 0, 0,    0, 0,  0,  1};
    vecs[16] = '{0, 105, 50, 0,  0, 0, 0,    0,  0, 0, 0,    0, 0, -1, -1};
    vecs[17] = '{0,   0,  0, 0,  0, 0, 0,    0,  0, 0, 1,    0, 0, -1, -1};
    vecs[18] = '{0,   0,  0, 0,  1, 0, 0,    0,  0, 0, 0,    0, 0, -1, -1};
    vecs[19] = '{1, 105, 50, 0,  0, 0, 0,    0,  0, 0, 0,  205, 1, -1, -1};
    vecs[20] = '{0,   0,  0, 1,  0, 0, 0,    0,  0, 0, 0,    0, 0, -1, -1};
    vecs[21] = '{1, 105, 50, 0,  0, 0, 0,    0,  0, 0, 0,  205, 1, -1, -1};

    model_clear();
    #1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("reset_wr_ready", int'(wr_ready), 1);
    chk("reset_note_on", int'(note_on), 0);

    // Directed vectors.
    for (int v = 0; v < 22; v++) begin
      step(vecs[v].pv, vecs[v].hc, vecs[v].vc, vecs[v].fs, vecs[v].wv, vecs[v].ws,
           vecs[v].we, vecs[v].wx, vecs[v].wy, vecs[v].wg, vecs[v].cm, 0);
      chk($sformatf("vec%0d_addr", v), int'(rom_addr), vecs[v].ea);
      chk($sformatf("vec%0d_glyph", v), int'(rom_glyph), vecs[v].eg);
      if (vecs[v].en >= 0) chk($sformatf("vec%0d_note_on", v), int'(note_on), vecs[v].en);
      if (vecs[v].epv >= 0) chk($sformatf("vec%0d_pov", v), int'(pix_out_valid), vecs[v].epv);
    end

    // Reset while streaming with a commit pending.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("seq_pending_set", int'(commit_pending), 1);
    step(1, 105, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 106, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 107, 50, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_note_on", int'(note_on), 0);
    chk("rst_pov", int'(pix_out_valid), 0);
    chk("rst_commit_pending", int'(commit_pending), 0);
    chk("rst_wr_ready", int'(wr_ready), 1);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 105, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_slots_cleared", int'(rom_addr), 0);
    step(1, 1020, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_slot5_cleared", int'(rom_glyph), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int hc, vc, wx;
      hc = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 140)) : int'($urandom_range(990, 1023));
      vc = int'($urandom_range(0, 80));
      wx = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 120)) : int'($urandom_range(995, 1023));
      step($urandom_range(0, 3) != 0, hc, vc, $urandom_range(0, 15) == 0,
           $urandom_range(0, 2) == 0, int'($urandom_range(0, NS - 1)),
           $urandom_range(0, 3) != 0, wx, int'($urandom_range(0, 50)),
           int'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
           $urandom_range(0, 399) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/note_sprite_scheduler.md
Name: note_sprite_scheduler

Overview:
- Shares one set of 20x30 note-glyph ROMs among up to NUM_SLOTS on-screen notes.
- For each VGA pixel it picks the highest-priority note whose box covers that pixel and drives the ROM address and glyph select.
- It then re-aligns the ROM's registered output with pixel coordinates and returns a composited note pixel.
- Note positions are loaded into a shadow table through a valid/ready port and applied atomically at frame start.

Parameters:
- NUM_SLOTS, 8, number of note slots (power of 2, 2..16).
- HW, 10, width of hcount/vcount and note x/y.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pix_valid  in  1  hcount/vcount valid (visible-area pixel) this cycle.
- hcount  in  HW  current pixel column.
- vcount  in  HW  current pixel row.
- frame_start  in  1  one-cycle pulse at first blanking line of frame.
- wr_valid  in  1  slot write request.
- wr_ready  out  1  slot write accepted when wr_valid & wr_ready.
- wr_slot  in  $clog2(NUM_SLOTS)  slot index.
- wr_en  in  1  slot enable bit to write.
- wr_x  in  HW  note box left column.
- wr_y  in  HW  note box top row.
- wr_glyph  in  2  glyph id (glyph_t).
- commit  in  1  request shadow->active copy at next frame_start.
- commit_pending  out  1  commit requested, not yet applied.
- rom_addr  out  10  shared glyph ROM address, row*20+col.
- rom_glyph  out  2  glyph select into ROM mux.
- rom_pixel  in  1  registered ROM output (1-cycle ROM latency).
- pix_out_valid  out  1  pix_valid delayed 3 cycles.
- note_on  out  1  composited pixel: 1 = note ink.

Behaviour:
- Reset: both tables all slots disabled (x=y=0, glyph=0). rom_addr=0, rom_glyph=0, note_on=0, pix_out_valid=0, commit_pending=0, wr_ready=1, FSM=LOAD.
- FSM LOAD: wr_ready=1. Accepted writes update the shadow slot next edge. commit=1 goes to PENDING and sets commit_pending. If commit and a write share a cycle, the write is applied and included in the commit.
- FSM PENDING: wr_ready=0, writes ignored. On frame_start the shadow table is copied into the active table in one edge, commit_pending is cleared, and the FSM returns to LOAD. commit=1 is ignored in PENDING.
- frame_start with no pending commit: no table change.
- Hit test, stage 0, combinational on the active table: slot i hits when enabled and x_i <= hcount < x_i+20 and y_i <= vcount < y_i+30. Compare in HW+1 bits, so boxes near the right or bottom edge do not wrap.
- Priority: lowest hit slot index wins. No hit, or pix_valid=0, forces hit=0.
- Stage 1 (registered, t+1): rom_addr = (vcount-y)*20 + (hcount-x) of the winner, or 0 if no hit. rom_glyph = winner's glyph. hit_d1 and valid_d1 are registered alongside. Multiply by 20 is done as shifts (<<4 + <<2); the result is 10 bits and at most 599.
- Stage 2 (t+2): the ROM presents rom_pixel. hit_d2 and valid_d2 are registered.
- Stage 3 (t+3): note_on = rom_pixel & hit_d2 & valid_d2. pix_out_valid = valid_d2.
- Total latency is 3 cycles from pix_valid/hcount to note_on. The pipeline is fully pipelined, one pixel per cycle, with no stalls.
- A commit applied mid-frame is impossible by construction (only on frame_start). A table copy on the frame_start edge affects pixels sampled from the next cycle on.
- reset mid-frame: the pipeline is flushed (outputs 0 next cycle), the pending commit is dropped, and both tables are cleared.

Decomposition:
- Package note_sprite_pkg holds:
  - SPRITE_W=20, SPRITE_H=30, SPRITE_DEPTH=600.
  - glyph_t enum: GLY_QTR_UP=0, GLY_QTR_DOWN=1, GLY_HALF=2, GLY_WHOLE=3.
  - slot_t struct {en, x, y, glyph}.
  - sched_state_t {S_LOAD, S_PENDING}.
- One sub-module, sprite_hit_prio: combinational NUM_SLOTS hit compare plus priority encoder, returning hit, winner index, local row and local col.
- ROMs and the glyph mux stay outside this block.

Test Plan:
- Reset, then drive pix_valid at hcount=100, vcount=50 with no slots → note_on=0 and pix_out_valid=1 exactly 3 cycles later; rom_addr=0.
- Write slot0 {en=1, x=100, y=40, glyph=1}, commit, then pulse frame_start. Drive hcount=105, vcount=50 → rom_addr=205 and rom_glyph=1 at t+1. With rom_pixel=1 → note_on=1 at t+3.
- Slot0 at (100,40) and slot3 at (110,40) overlap. Drive hcount=112, vcount=45 → slot0 wins: rom_addr=5*20+12=112, rom_glyph=slot0 glyph.
- Edge wrap: slot at x=1015, y=0. Drive hcount=1020 → rom_addr=5. Drive hcount=3 → no hit, note_on=0.
- Assert commit, then attempt wr_valid while PENDING → wr_ready=0 and the shadow is unchanged. Active table is unchanged until frame_start, then updated; commit_pending falls the cycle after frame_start.
- Raise reset during a streaming pixel run with commit pending → next cycle note_on=0, pix_out_valid=0, commit_pending=0, wr_ready=1, all slots disabled.
